// File: rtl/trace_width_ctrl.sv
// rtl/trace_width_ctrl.sv - width-discovery and sequencing controller for the trace input datapath
//
// Purpose:
//   Drives the trace datapath bus width and its reset, and watches the
//   datapath's sync indication. In auto mode the controller hunts through
//   widths 4 -> 2 -> 1 -> 4 ... until sync holds for CONFIRM_CYCLES, then
//   locks; on sync loss it retries the current width before scanning again.
//   In manual mode it applies the host-configured width.
//
// Parameters:
//   DWELL_CYCLES    clk cycles spent hunting at one width (max 2^24-1)
//   FLUSH_CYCLES    cycles dpRst is held after a width change (1..255)
//   CONFIRM_CYCLES  consecutive sync-high cycles needed to lock (1..255)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   autoEn     in   1 = auto width hunt, 0 = manual width
//   cfgWidth   in   manual width (1, 2, 4; anything else treated as 4)
//   sync       in   datapath sync indication (clk domain)
//   width      out  width driven to the datapath (registered)
//   dpRst      out  datapath reset, high exactly while in FLUSH
//   locked     out  LOCKED state (auto) or registered sync (manual)
//   searching  out  HUNT or FLUSH while autoEn is high
//   passCount  out  full 4/2/1 scans without lock, saturating at 255
//   lossCount  out  (only with TRACE_WIDTH_STATS_EN) sync-loss count, saturating
//
// Optional feature macro: TRACE_WIDTH_STATS_EN adds the lossCount output.

module trace_width_ctrl #(
  parameter int DWELL_CYCLES   = 1000000,
  parameter int FLUSH_CYCLES   = 8,
  parameter int CONFIRM_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        autoEn,
  input  logic [2:0]  cfgWidth,
  input  logic        sync,
  output logic [2:0]  width,
  output logic        dpRst,
  output logic        locked,
  output logic        searching,
  output logic [7:0]  passCount
`ifdef TRACE_WIDTH_STATS_EN
  ,
  output logic [15:0] lossCount
`endif
);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FIXED  = 2'd3
  } state_t;

  localparam logic [23:0] DWELL_LAST  = 24'(DWELL_CYCLES - 1);
  localparam logic [7:0]  FLUSH_LAST  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0]  CONFIRM_PRE = 8'(CONFIRM_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  width_q, width_d;
  logic [7:0]  flush_q, flush_d;
  logic [23:0] dwell_q, dwell_d;
  logic [7:0]  confirm_q, confirm_d;
  logic        locked_q, locked_d;
  logic [7:0]  pass_q, pass_d;
`ifdef TRACE_WIDTH_STATS_EN
  logic [15:0] loss_q, loss_d;
`endif

  logic [2:0]  cfg_san;
  logic [2:0]  width_next;

  // Illegal manual widths fall back to the widest bus.
  always_comb begin
    cfg_san = 3'd4;
    if (cfgWidth == 3'd1 || cfgWidth == 3'd2 || cfgWidth == 3'd4) begin
      cfg_san = cfgWidth;
    end
  end

  // Scan order 4 -> 2 -> 1 -> 4.
  always_comb begin
    width_next = 3'd4;
    if (width_q == 3'd4) begin
      width_next = 3'd2;
    end else if (width_q == 3'd2) begin
      width_next = 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    flush_d   = flush_q;
    dwell_d   = dwell_q;
    confirm_d = confirm_q;
    pass_d    = pass_q;
`ifdef TRACE_WIDTH_STATS_EN
    loss_d    = loss_q;
`endif

    case (state_q)
      ST_FLUSH: begin
        // autoEn is only looked at when the flush completes.
        if (flush_q == FLUSH_LAST) begin
          flush_d   = 8'd0;
          dwell_d   = 24'd0;
          confirm_d = 8'd0;
          state_d   = autoEn ? ST_HUNT : ST_FIXED;
        end else begin
          flush_d = flush_q + 8'd1;
        end
      end

      ST_HUNT: begin
        if (!autoEn) begin
          // Leaving auto mode: only flush if the bus width actually changes.
          dwell_d   = 24'd0;
          confirm_d = 8'd0;
          if (cfg_san != width_q) begin
            width_d = cfg_san;
            flush_d = 8'd0;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_FIXED;
          end
        end else if (sync && confirm_q == CONFIRM_PRE) begin
          // Lock wins over dwell expiry landing on the same cycle.
          dwell_d   = 24'd0;
          confirm_d = 8'd0;
          state_d   = ST_LOCKED;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d   = 24'd0;
          confirm_d = 8'd0;
          width_d   = width_next;
          flush_d   = 8'd0;
          state_d   = ST_FLUSH;
          if (width_q == 3'd1 && pass_q != 8'hFF) begin
            pass_d = pass_q + 8'd1;
          end
        end else begin
          dwell_d   = dwell_q + 24'd1;
          confirm_d = sync ? confirm_q + 8'd1 : 8'd0;
        end
      end

      ST_LOCKED: begin
        if (!autoEn) begin
          if (cfg_san != width_q) begin
            width_d = cfg_san;
            flush_d = 8'd0;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_FIXED;
          end
        end else if (!sync) begin
          // Retry the width that was working before resuming the scan.
          dwell_d   = 24'd0;
          confirm_d = 8'd0;
          state_d   = ST_HUNT;
`ifdef TRACE_WIDTH_STATS_EN
          if (loss_q != 16'hFFFF) begin
            loss_d = loss_q + 16'd1;
          end
`endif
        end
      end

      ST_FIXED: begin
        if (autoEn) begin
          dwell_d   = 24'd0;
          confirm_d = 8'd0;
          state_d   = ST_HUNT;
        end else if (cfg_san != width_q) begin
          width_d = cfg_san;
          flush_d = 8'd0;
          state_d = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_FLUSH;
        flush_d = 8'd0;
      end
    endcase

    // A lock means the scan history is no longer interesting.
    if (state_d == ST_LOCKED) begin
      pass_d = 8'd0;
    end

    // In manual mode locked simply follows sync one cycle late.
    locked_d = (state_d == ST_LOCKED) || (state_d == ST_FIXED && sync);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FLUSH;
      width_q   <= 3'd4;
      flush_q   <= 8'd0;
      dwell_q   <= 24'd0;
      confirm_q <= 8'd0;
      locked_q  <= 1'b0;
      pass_q    <= 8'd0;
`ifdef TRACE_WIDTH_STATS_EN
      loss_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      flush_q   <= flush_d;
      dwell_q   <= dwell_d;
      confirm_q <= confirm_d;
      locked_q  <= locked_d;
      pass_q    <= pass_d;
`ifdef TRACE_WIDTH_STATS_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign width     = width_q;
  assign dpRst     = (state_q == ST_FLUSH);
  assign locked    = locked_q;
  // Masked while rst is high so searching reads 0 throughout reset.
  assign searching = !rst && autoEn && (state_q == ST_HUNT || state_q == ST_FLUSH);
  assign passCount = pass_q;
`ifdef TRACE_WIDTH_STATS_EN
  assign lossCount = loss_q;
`endif

endmodule

// File: tb/tb_trace_width_ctrl.sv
// tb/tb_trace_width_ctrl.sv - directed scoreboard bench for trace_width_ctrl

module tb_trace_width_ctrl;

  logic        clk;
  logic        rst;
  logic        autoEn;
  logic [2:0]  cfgWidth;
  logic        sync;
  logic [2:0]  width;
  logic        dpRst;
  logic        locked;
  logic        searching;
  logic [7:0]  passCount;
`ifdef TRACE_WIDTH_STATS_EN
  logic [15:0] lossCount;
`endif

  int checks;
  int errors;
  int n;
  int cyc;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  trace_width_ctrl #(
    .DWELL_CYCLES  (100),
    .FLUSH_CYCLES  (4),
    .CONFIRM_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .autoEn   (autoEn),
    .cfgWidth (cfgWidth),
    .sync     (sync),
    .width    (width),
    .dpRst    (dpRst),
    .locked   (locked),
    .searching(searching),
    .passCount(passCount)
`ifdef TRACE_WIDTH_STATS_EN
    ,
    .lossCount(lossCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clocks; outputs are observed 1 time unit after the edge.
  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [15:0] expv);
    tag_q.push_back(tag);
    exp_q.push_back(expv);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    logic [15:0] expv;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
    end else begin
      expv = exp_q.pop_front();
      tag  = tag_q.pop_front();
      assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
    end
  endtask

  task automatic chk_now(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    push(tag, expv);
    pop_chk(obs);
  endtask

  // Counts consecutive sampled cycles with dpRst high, starting now.
  task automatic count_dprst(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (dpRst !== 1'b1) break;
      cnt++;
      step(1);
    end
  endtask

  // Cycles until width changes from its current value, bounded.
  task automatic wait_width_change(input int maxc, output int cnt);
    logic [2:0] w0;
    w0  = width;
    cnt = 0;
    while (width === w0 && cnt < maxc) begin
      step(1);
      cnt++;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    autoEn   = 1'b1;
    cfgWidth = 3'd4;
    sync     = 1'b0;

    // Reset state
    step(2);
    chk_now("rst_width", 16'(width), 16'd4);
    chk_now("rst_dprst", 16'(dpRst), 16'd1);
    chk_now("rst_locked", 16'(locked), 16'd0);
    chk_now("rst_searching", 16'(searching), 16'd0);
    chk_now("rst_pass", 16'(passCount), 16'd0);
`ifdef TRACE_WIDTH_STATS_EN
    chk_now("rst_loss", lossCount, 16'd0);
`endif
    rst = 1'b0;

    // Initial flush and first hunt at width 4
    count_dprst(n);
    chk_now("flush_len_init", 16'(n), 16'd4);
    chk_now("hunt4_width", 16'(width), 16'd4);
    chk_now("hunt4_searching", 16'(searching), 16'd1);

    // Scan 4 -> 2 -> 1 -> 4, 104 cycles per width
    wait_width_change(200, cyc);
    chk_now("scan_4to2_cycles", 16'(cyc + 4), 16'd104);
    chk_now("scan_w2", 16'(width), 16'd2);
    wait_width_change(200, cyc);
    chk_now("scan_2to1_cycles", 16'(cyc), 16'd104);
    chk_now("scan_w1", 16'(width), 16'd1);
    chk_now("scan_pass_before_wrap", 16'(passCount), 16'd0);
    wait_width_change(200, cyc);
    chk_now("scan_1to4_cycles", 16'(cyc), 16'd104);
    chk_now("scan_wrap_w4", 16'(width), 16'd4);
    chk_now("scan_wrap_pass", 16'(passCount), 16'd1);

    // Move to width 2 hunt, dwell 0
    wait_width_change(200, cyc);
    chk_now("second_w2", 16'(width), 16'd2);
    step(4);
    chk_now("hunt2_no_dprst", 16'(dpRst), 16'd0);

    // 7-cycle sync pulse: no lock
    step(20);
    sync = 1'b1;
    push("pulse7_locked_during", 16'd0);
    step(7);
    pop_chk(16'(locked));
    sync = 1'b0;
    push("pulse7_locked_after", 16'd0);
    step(1);
    pop_chk(16'(locked));

    // 8-cycle sync at dwell 50: lock
    step(22);
    sync = 1'b1;
    push("pulse8_locked_at7", 16'd0);
    step(7);
    pop_chk(16'(locked));
    push("lock_locked", 16'd1);
    push("lock_width", 16'd2);
    push("lock_pass_cleared", 16'd0);
    push("lock_no_dprst", 16'd0);
    push("lock_not_searching", 16'd0);
    step(1);
    pop_chk(16'(locked));
    pop_chk(16'(width));
    pop_chk(16'(passCount));
    pop_chk(16'(dpRst));
    pop_chk(16'(searching));

    // Sync loss: back to HUNT at the same width, no flush
    sync = 1'b0;
    push("loss_locked", 16'd0);
    push("loss_width", 16'd2);
    push("loss_no_dprst", 16'd0);
    push("loss_searching", 16'd1);
    step(1);
    pop_chk(16'(locked));
    pop_chk(16'(width));
    pop_chk(16'(dpRst));
    pop_chk(16'(searching));
`ifdef TRACE_WIDTH_STATS_EN
    chk_now("loss_count", lossCount, 16'd1);
`endif
    step(1);
    chk_now("loss_no_dprst_later", 16'(dpRst), 16'd0);

    // Manual mode with illegal cfgWidth -> width 4
    autoEn   = 1'b0;
    cfgWidth = 3'd3;
    push("man3_width", 16'd4);
    push("man3_dprst", 16'd1);
    push("man3_searching", 16'd0);
    step(1);
    pop_chk(16'(width));
    pop_chk(16'(dpRst));
    pop_chk(16'(searching));
    count_dprst(n);
    chk_now("man3_flush_len", 16'(n), 16'd4);
    chk_now("man3_fixed_width", 16'(width), 16'd4);

    // Manual locked mirrors sync
    sync = 1'b1;
    push("fixed_locked_hi", 16'd1);
    step(1);
    pop_chk(16'(locked));
    sync = 1'b0;
    push("fixed_locked_lo", 16'd0);
    step(1);
    pop_chk(16'(locked));

    // Manual width change to 1
    cfgWidth = 3'd1;
    push("man1_dprst", 16'd1);
    push("man1_width", 16'd1);
    step(1);
    pop_chk(16'(dpRst));
    pop_chk(16'(width));
    count_dprst(n);
    chk_now("man1_flush_len", 16'(n), 16'd4);
    chk_now("man1_width_after", 16'(width), 16'd1);
    chk_now("man1_searching", 16'(searching), 16'd0);

    // Back to auto: hunt at current width
    autoEn = 1'b1;
    push("auto_resume_width", 16'd1);
    push("auto_resume_dprst", 16'd0);
    push("auto_resume_searching", 16'd1);
    step(1);
    pop_chk(16'(width));
    pop_chk(16'(dpRst));
    pop_chk(16'(searching));
    wait_width_change(200, cyc);
    chk_now("resume_1to4_cycles", 16'(cyc), 16'd100);
    chk_now("resume_pass", 16'(passCount), 16'd1);
    wait_width_change(200, cyc);
    wait_width_change(200, cyc);
    chk_now("pre_rst_w1", 16'(width), 16'd1);

    // Reset mid-flush at width 1
    step(2);
    rst = 1'b1;
    push("midrst_width", 16'd4);
    push("midrst_pass", 16'd0);
    push("midrst_dprst", 16'd1);
    step(1);
    pop_chk(16'(width));
    pop_chk(16'(passCount));
    pop_chk(16'(dpRst));
`ifdef TRACE_WIDTH_STATS_EN
    chk_now("midrst_loss", lossCount, 16'd0);
`endif
    rst = 1'b0;
    count_dprst(n);
    chk_now("midrst_flush_len", 16'(n), 16'd4);

    // Confirm completes on the dwell-expiry cycle
    step(92);
    sync = 1'b1;
    push("edge_locked", 16'd1);
    push("edge_width", 16'd4);
    push("edge_no_dprst", 16'd0);
    step(8);
    pop_chk(16'(locked));
    pop_chk(16'(width));
    pop_chk(16'(dpRst));
    step(1);
    chk_now("edge_still_locked", 16'(locked), 16'd1);
    chk_now("edge_still_no_dprst", 16'(dpRst), 16'd0);

    // Leave auto with matching cfgWidth: straight to FIXED
    cfgWidth = 3'd4;
    autoEn   = 1'b0;
    push("direct_fixed_dprst", 16'd0);
    push("direct_fixed_width", 16'd4);
    push("direct_fixed_locked", 16'd1);
    push("direct_fixed_searching", 16'd0);
    step(1);
    pop_chk(16'(dpRst));
    pop_chk(16'(width));
    pop_chk(16'(locked));
    pop_chk(16'(searching));
    step(1);
    chk_now("direct_fixed_stays", 16'(dpRst), 16'd0);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
